// File: rtl/shift_serdes_pkg.sv
// shift_pkg: shared TX state type, divider floor and parity helper for shift_serdes.
package shift_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t;

    localparam int DIV_MIN = 2;

    function automatic logic even_parity(input logic [31:0] d, input int w);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) p = p ^ d[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/shift_serdes_bit_timer.sv
// shift_bit_timer: bit-period divider (div_cnt) and bit counter (bit_cnt) for the TX path.
module shift_bit_timer
    import shift_pkg::*;
#(
    parameter int DIV   = 2,
    parameter int NBITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic strobe,
    output logic pre_strobe,
    output logic last_bit
);

    localparam int DIV_E = (DIV < DIV_MIN) ? DIV_MIN : DIV;
    localparam int DW    = $clog2(DIV_E);
    localparam int BW    = $clog2(NBITS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_E - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(DIV_E - 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;

    // pre_strobe lets the owner register its strobe output one cycle ahead
    assign strobe     = run && (div_cnt == DIV_LAST);
    assign pre_strobe = run && (div_cnt == DIV_PRE);
    assign last_bit   = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (run) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_serdes.sv
// shift_serdes: serial link with independent PISO transmitter and SIPO receiver.
// Build option SHIFT_SERDES_PARITY_EN appends/checks an even-parity bit per word.
module shift_serdes
    import shift_pkg::*;
#(
    parameter int W         = 8,
    parameter int DIV       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] tx_data,
    output logic         tx_busy,
    output logic         tx_done,
    output logic         ser_out,
    output logic         ser_frame,
    output logic         ser_strobe,
    input  logic         ser_in,
    input  logic         ser_frame_in,
    input  logic         ser_strobe_in,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    output logic         rx_err
);

`ifdef SHIFT_SERDES_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FW = W + PAR;
    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] RX_FULL = CW'(FW);

    tx_state_t     state, state_n;
    logic [FW-1:0] tx_sreg, tx_sreg_n, load_word, tx_shifted;
    logic          busy_n, done_n, frame_n, out_n, strobe_n;
    logic          first_bit, next_bit;
    logic          t_strobe, t_pre, t_last;

    shift_bit_timer #(
        .DIV   (DIV),
        .NBITS (FW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (state != SHIFT),
        .run        (state == SHIFT),
        .strobe     (t_strobe),
        .pre_strobe (t_pre),
        .last_bit   (t_last)
    );

`ifdef SHIFT_SERDES_PARITY_EN
    logic [31:0] tx_ext;
    logic        tx_par;

    always_comb begin
        tx_ext         = '0;
        tx_ext[W-1:0]  = tx_data;
        tx_par         = even_parity(tx_ext, W);
    end

    // parity always trails the data, so it sits at the far end of the shift direction
    assign load_word = (MSB_FIRST != 0) ? {tx_data, tx_par} : {tx_par, tx_data};
`else
    assign load_word = tx_data;
`endif

    assign first_bit  = (MSB_FIRST != 0) ? load_word[FW-1] : load_word[0];
    assign tx_shifted = (MSB_FIRST != 0) ? {tx_sreg[FW-2:0], 1'b0} : {1'b0, tx_sreg[FW-1:1]};
    assign next_bit   = (MSB_FIRST != 0) ? tx_shifted[FW-1] : tx_shifted[0];

    always_comb begin
        state_n   = state;
        tx_sreg_n = tx_sreg;
        busy_n    = tx_busy;
        done_n    = 1'b0;
        frame_n   = ser_frame;
        out_n     = ser_out;
        strobe_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SHIFT;
                    tx_sreg_n = load_word;
                    busy_n    = 1'b1;
                    frame_n   = 1'b1;
                    out_n     = first_bit;
                end
            end
            SHIFT: begin
                strobe_n = t_pre && !t_strobe;
                if (t_strobe) begin
                    if (t_last) begin
                        state_n = DONE;
                        frame_n = 1'b0;
                        out_n   = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        tx_sreg_n = tx_shifted;
                        out_n     = next_bit;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                frame_n = 1'b0;
                out_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tx_sreg    <= '0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            ser_frame  <= 1'b0;
            ser_out    <= 1'b0;
            ser_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            tx_sreg    <= tx_sreg_n;
            tx_busy    <= busy_n;
            tx_done    <= done_n;
            ser_frame  <= frame_n;
            ser_out    <= out_n;
            ser_strobe <= strobe_n;
        end
    end

    // ---------------- receive path ----------------
    logic [FW-1:0] rx_sreg, rx_shifted;
    logic [CW-1:0] rx_cnt;
    logic [W-1:0]  rx_word;
    logic          rx_ok, rx_take, frame_q;

    assign rx_take    = ser_frame_in && ser_strobe_in;
    assign rx_shifted = (MSB_FIRST != 0) ? {rx_sreg[FW-2:0], ser_in} : {ser_in, rx_sreg[FW-1:1]};

`ifdef SHIFT_SERDES_PARITY_EN
    logic [31:0] rx_ext;
    logic        rx_pbit;

    always_comb begin
        rx_ext = '0;
        if (MSB_FIRST != 0) begin
            rx_word = rx_sreg[FW-1:1];
            rx_pbit = rx_sreg[0];
        end else begin
            rx_word = rx_sreg[W-1:0];
            rx_pbit = rx_sreg[W];
        end
        rx_ext[W-1:0] = rx_word;
        rx_ok         = (even_parity(rx_ext, W) == rx_pbit);
    end
`else
    always_comb begin
        rx_word = rx_sreg;
        rx_ok   = 1'b1;
    end
`endif

    // a full word is retired one cycle after its last bit; an early frame drop discards it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sreg  <= '0;
            rx_cnt   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            frame_q  <= ser_frame_in;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (rx_cnt == RX_FULL) begin
                if (rx_ok) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end else begin
                    rx_err <= 1'b1;
                end
                if (rx_take) begin
                    rx_sreg <= rx_shifted;
                    rx_cnt  <= CW'(1);
                end else begin
                    rx_cnt <= '0;
                end
            end else if (frame_q && !ser_frame_in && (rx_cnt != '0)) begin
                rx_err <= 1'b1;
                rx_cnt <= '0;
            end else if (rx_take) begin
                rx_sreg <= rx_shifted;
                rx_cnt  <= rx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_serdes.sv
// tb_shift_serdes: directed loopback/link bench for shift_serdes with an RX scoreboard.
module tb_shift_serdes;

`ifdef SHIFT_SERDES_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int W    = 8;
    localparam int DIV  = 2;
    localparam int FB   = W + PAR;
    localparam int FLEN = FB * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic       busy_m, done_m, out_m, frame_m, strobe_m, rxv_m, rxe_m;
    logic [7:0] rxd_m;
    logic       busy_l, done_l, out_l, frame_l, strobe_l, rxv_l, rxe_l;
    logic [7:0] rxd_l;

    logic loop_m = 1'b1;
    logic lnk_in = 1'b0, lnk_frame = 1'b0, lnk_strobe = 1'b0;
    logic sin_m, sfr_m, sst_m;

    assign sin_m = loop_m ? out_m    : lnk_in;
    assign sfr_m = loop_m ? frame_m  : lnk_frame;
    assign sst_m = loop_m ? strobe_m : lnk_strobe;

    int n_tests = 0;
    int n_fail  = 0;
    int err_m   = 0;
    int err_l   = 0;
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    logic [7:0] e_m, e_l;

    always #5 clk = ~clk;

    shift_serdes #(.W(W), .DIV(DIV), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .tx_busy(busy_m), .tx_done(done_m), .ser_out(out_m), .ser_frame(frame_m),
        .ser_strobe(strobe_m), .ser_in(sin_m), .ser_frame_in(sfr_m), .ser_strobe_in(sst_m),
        .rx_data(rxd_m), .rx_valid(rxv_m), .rx_err(rxe_m)
    );

    shift_serdes #(.W(W), .DIV(DIV), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .tx_busy(busy_l), .tx_done(done_l), .ser_out(out_l), .ser_frame(frame_l),
        .ser_strobe(strobe_l), .ser_in(out_l), .ser_frame_in(frame_l), .ser_strobe_in(strobe_l),
        .rx_data(rxd_l), .rx_valid(rxv_l), .rx_err(rxe_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int idx, input bit msb);
        if (idx >= W) return ^d;
        return msb ? d[W-1-idx] : d[idx];
    endfunction

    // scoreboard: every rx_valid must match the oldest word still outstanding
    always @(negedge clk) begin
        if (rxv_m === 1'b1) begin
            if (q_m.size() == 0) chk("rx_valid_m_unexpected", rxv_m, 0);
            else begin
                e_m = q_m.pop_front();
                chk("rx_data_m", rxd_m, e_m);
            end
        end
        if (rxv_l === 1'b1) begin
            if (q_l.size() == 0) chk("rx_valid_l_unexpected", rxv_l, 0);
            else begin
                e_l = q_l.pop_front();
                chk("rx_data_l", rxd_l, e_l);
            end
        end
        if (rxe_m === 1'b1) err_m++;
        if (rxe_l === 1'b1) err_l++;
    end

    // call at a negedge of an idle cycle; returns at the negedge of the first idle cycle after DONE
    task automatic run_frame(input logic [7:0] d, input bit poke);
        start   = 1'b1;
        tx_data = d;
        q_m.push_back(d);
        q_l.push_back(d);
        for (int i = 0; i < FLEN; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start   = 1'b0;
                tx_data = 8'hFF;
            end
            if (poke && i == 5) start = 1'b1;
            if (poke && i == 6) start = 1'b0;
            chk("ser_frame", frame_m, 1);
            chk("tx_busy", busy_m, 1);
            chk("ser_out_msb", out_m, exp_bit(d, i / DIV, 1'b1));
            chk("ser_out_lsb", out_l, exp_bit(d, i / DIV, 1'b0));
            chk("ser_strobe", strobe_m, ((i % DIV) == DIV - 1));
        end
        @(negedge clk);
        chk("done_frame", frame_m, 0);
        chk("done_pulse", done_m, 1);
        chk("done_busy", busy_m, 1);
        chk("done_out", out_m, 0);
        if (poke) begin
            start   = 1'b1;
            tx_data = 8'hFF;
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", busy_m, 0);
        chk("idle_done", done_m, 0);
    endtask

    task automatic drive_word(input logic [7:0] d, input int n, input bit bad);
        lnk_frame = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            lnk_strobe = 1'b1;
            lnk_in     = (bad && k == W) ? ~exp_bit(d, k, 1'b1) : exp_bit(d, k, 1'b1);
            @(negedge clk);
            lnk_strobe = 1'b0;
        end
        @(negedge clk);
        lnk_frame = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_m, 0);
        chk("rst_done", done_m, 0);
        chk("rst_out", out_m, 0);
        chk("rst_frame", frame_m, 0);
        chk("rst_strobe", strobe_m, 0);
        chk("rst_rxd", rxd_m, 0);
        chk("rst_rxv", rxv_m, 0);
        chk("rst_rxe", rxe_m, 0);
        chk("rst_frame_l", frame_l, 0);
        reset = 1'b1;
        @(negedge clk);

        // LSB/MSB ordering, then a poked frame, then acceptance in the first idle cycle
        run_frame(8'hA3, 1'b0);
        run_frame(8'h11, 1'b1);
        run_frame(8'h11, 1'b0);
        repeat (3) @(negedge clk);
        chk("rxd_after_11", rxd_m, 8'h11);

        // receiver driven directly: stray strobes, early abort, then a clean word
        loop_m = 1'b0;
        repeat (2) begin
            @(negedge clk); lnk_strobe = 1'b1; lnk_in = 1'b1;
            @(negedge clk); lnk_strobe = 1'b0;
        end
        drive_word(8'hB5, 3, 1'b0);
        @(negedge clk);
        chk("abort_err", rxe_m, 1);
        chk("abort_valid", rxv_m, 0);
        chk("abort_hold", rxd_m, 8'h11);
        @(negedge clk);
        chk("abort_err_pulse", rxe_m, 0);
        q_m.push_back(8'h5A);
        drive_word(8'h5A, FB, 1'b0);
        repeat (3) @(negedge clk);
        loop_m = 1'b1;
        @(negedge clk);

        // reset in the sixth frame cycle
        start   = 1'b1;
        tx_data = 8'hC6;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_frame", frame_m, 0);
        chk("mid_rst_busy", busy_m, 0);
        chk("mid_rst_out", out_m, 0);
        chk("mid_rst_rxd", rxd_m, 0);
        chk("mid_rst_frame_l", frame_l, 0);
        chk("mid_rst_rxd_l", rxd_l, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", done_m, 0);
            chk("post_rst_rxv", rxv_m, 0);
        end
        run_frame(8'h96, 1'b0);
        repeat (3) @(negedge clk);

`ifdef SHIFT_SERDES_PARITY_EN
        run_frame(8'h07, 1'b0);
        repeat (3) @(negedge clk);
        chk("par_rxd", rxd_m, 8'h07);
        loop_m = 1'b1;
        loop_m = 1'b0;
        drive_word(8'h07, FB, 1'b1);
        repeat (3) @(negedge clk);
        chk("par_bad_hold", rxd_m, 8'h07);
        loop_m = 1'b1;
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty_m", q_m.size(), 0);
        chk("sb_empty_l", q_l.size(), 0);
        chk("err_count_m", err_m, 1 + PAR);
        chk("err_count_l", err_l, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_serdes.md
Name: shift_serdes

Overview:
Parametrised serial link block with a transmit path (parallel-in/serial-out) and a receive path (serial-in/parallel-out). It has a start/busy/done handshake, a built-in bit-period divider, a frame/strobe pair and selectable bit order. TX and RX are independent, so two instances, or one in loopback, form a complete word link between subsystems.

Parameters:
W, 8, data word width in bits (2..32)
DIV, 2, clk cycles per serial bit (>=2)
MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB first

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request to transmit tx_data; sampled only when tx_busy=0
tx_data  in  W  word to send, latched in the start cycle
tx_busy  out  1  transmitter occupied
tx_done  out  1  1-cycle pulse at end of frame
ser_out  out  1  serial data
ser_frame  out  1  high for the whole frame
ser_strobe  out  1  1-cycle pulse on last cycle of each bit period
ser_in  in  1  serial data from link
ser_frame_in  in  1  link frame
ser_strobe_in  in  1  link strobe; RX samples ser_in when high and frame high
rx_data  out  W  last complete received word
rx_valid  out  1  1-cycle pulse, rx_data updated
rx_err  out  1  1-cycle pulse, frame aborted early (or parity error, see option)

Behaviour:
- Reset (reset=0, async): all outputs 0, rx_data=0, TX FSM=IDLE, counters=0, RX shift reg and bit count=0.
- TX FSM states: IDLE, SHIFT, DONE. All TX outputs are registered.
- IDLE, start=1 at edge 0: latch tx_data into shift reg. From cycle 1: tx_busy=1, ser_frame=1, ser_out=first bit, div_cnt=0, bit_cnt=0.
- SHIFT:
  - Each bit is held DIV cycles. ser_strobe=1 when div_cnt==DIV-1.
  - On that cycle's edge: shift the register, bit_cnt+1, div_cnt wraps to 0.
  - After bit W-1's strobe: go to DONE. ser_frame=0, ser_out=0.
  - Frame length is exactly W*DIV cycles.
- DONE: tx_done=1 and tx_busy=1 for one cycle, then IDLE with tx_busy=0. start in the DONE cycle is ignored. Earliest next accepted start is the first IDLE cycle.
- start while tx_busy=1 is ignored; tx_data changes during the frame have no effect.
- Bit order: MSB_FIRST=1 shifts left and drives reg[W-1]; MSB_FIRST=0 shifts right and drives reg[0].
- RX, each cycle with ser_frame_in=1 and ser_strobe_in=1:
  - Shift ser_in into the RX register, same bit order as TX (MSB_FIRST=1: bit enters at [0], shifting left).
  - rx_cnt+1.
- When rx_cnt reaches W: rx_data is loaded next edge, rx_valid pulses the cycle rx_data changes, rx_cnt clears.
- Strobes after W bits within one frame start a new word.
- ser_frame_in falling with 0<rx_cnt<W: rx_err pulse 1 cycle later, rx_cnt cleared, rx_data unchanged.
- Strobe without frame: ignored.
- Reset mid-frame: everything returns to reset values at once. No tx_done, rx_valid or rx_err is generated.
- Counter widths are $clog2 of W+1 and DIV. Counters never exceed W and DIV-1.

Optional Feature:
Macro SHIFT_SERDES_PARITY_EN.
- Defined:
  - TX appends one even-parity bit (XOR of the data bits) after the data. Frame is (W+1)*DIV cycles.
  - RX expects W+1 bits. On mismatch it pulses rx_err instead of rx_valid and leaves rx_data unchanged.
- Undefined: no parity bit; frame is W bits; rx_err only flags early frame abort.

Decomposition:
- Package shift_pkg holds:
  - typedef enum for tx_state_t {IDLE, SHIFT, DONE}
  - localparam DIV_MIN=2
  - function even_parity(input logic [31:0] d, int w)
- One sub-module, shift_bit_timer: div_cnt and bit_cnt, with strobe and last_bit outputs, parametrised by DIV and bit count. Instantiated by the TX path.

Test Plan:
- W=8, DIV=2, MSB_FIRST=1, loopback (ser_out->ser_in etc.), start with tx_data=8'h11:
  - ser_out sequence 0,0,0,1,0,0,0,1, each held 2 cycles
  - ser_frame high 16 cycles; tx_done 1 cycle after frame falls
  - rx_valid with rx_data=8'h11
- MSB_FIRST=0, tx_data=8'hA3 -> ser_out bits 1,1,0,0,0,1,0,1; rx_data=8'hA3.
- start pulsed again mid-frame and in the DONE cycle with tx_data=8'hFF -> ignored, frame content stays 8'h11; start in the first IDLE cycle is accepted.
- Drive ser_frame_in low after 3 strobes -> rx_err pulse, no rx_valid, rx_data keeps previous value 8'h11.
- Assert reset=0 in cycle 6 of a frame -> ser_frame, tx_busy, ser_out and rx_data=0 immediately; no tx_done; the next start transmits normally.
- With SHIFT_SERDES_PARITY_EN, tx_data=8'h07 -> 9th bit=1, frame 18 cycles, rx_valid. Forcing the parity bit to 0 on the link -> rx_err, no rx_valid.
